// File: rtl/counter_multimode_pkg.sv
// counter_pkg: shared types for the multimode bounded counter.
//   cnt_mode_e  - runtime counting mode (WRAP / SAT / ONESHOT)
//   cnt_state_e - one-shot sequencer state
//   decode_mode - maps the raw 2-bit mode field, reserved 2'b11 -> WRAP
package counter_pkg;

  typedef enum logic [1:0] {
    CNT_WRAP    = 2'd0,
    CNT_SAT     = 2'd1,
    CNT_ONESHOT = 2'd2
  } cnt_mode_e;

  typedef enum logic [1:0] {
    CNT_IDLE = 2'd0,
    CNT_RUN  = 2'd1,
    CNT_DONE = 2'd2
  } cnt_state_e;

  function automatic cnt_mode_e decode_mode(input logic [1:0] m);
    case (m)
      2'd1:    return CNT_SAT;
      2'd2:    return CNT_ONESHOT;
      default: return CNT_WRAP;
    endcase
  endfunction

endpackage

// File: rtl/counter_multimode_if.sv
// Control/status bundle of the multimode counter.
//   en, dir, step, mode, start, load_en, load_count : controls into the counter
//   count, tc, ovf, busy                            : registered status out
// master: the controlling agent; slave: the counter itself.
interface counter_multimode_if #(
  parameter int unsigned COUNT_WIDTH = 8,
  parameter int unsigned STEP_WIDTH  = 4
) ();
  logic                   en;
  logic                   dir;
  logic [STEP_WIDTH-1:0]  step;
  logic [1:0]             mode;
  logic                   start;
  logic                   load_en;
  logic [COUNT_WIDTH-1:0] load_count;
  logic [COUNT_WIDTH-1:0] count;
  logic                   tc;
  logic                   ovf;
  logic                   busy;

  modport master (
    output en, dir, step, mode, start, load_en, load_count,
    input  count, tc, ovf, busy
  );

  modport slave (
    input  en, dir, step, mode, start, load_en, load_count,
    output count, tc, ovf, busy
  );
endinterface

// File: rtl/counter_multimode_next.sv
// counter_next: combinational next-count generator for one bounded counter.
//   i_count/i_dir/i_step/i_mode -> o_next (bounded next value),
//   o_hit_bound (event that raises tc: wrap in WRAP, entering a bound in SAT,
//   reaching the far bound in ONESHOT), o_clamped (overshoot was clamped).
// A step of zero holds the count and reports nothing.
module counter_next
  import counter_pkg::*;
#(
  parameter int unsigned COUNT_WIDTH = 8,
  parameter int unsigned STEP_WIDTH  = 4,
  parameter int unsigned COUNT_FROM  = 0,
  parameter int unsigned COUNT_TO    = 255
) (
  input  logic [COUNT_WIDTH-1:0] i_count,
  input  logic                   i_dir,
  input  logic [STEP_WIDTH-1:0]  i_step,
  input  cnt_mode_e              i_mode,
  output logic [COUNT_WIDTH-1:0] o_next,
  output logic                   o_hit_bound,
  output logic                   o_clamped
);
  localparam int unsigned            WW     = COUNT_WIDTH + STEP_WIDTH + 1;
  localparam logic [WW-1:0]          FROM_W = WW'(COUNT_FROM);
  localparam logic [WW-1:0]          TO_W   = WW'(COUNT_TO);
  localparam logic [COUNT_WIDTH-1:0] FROM_C = COUNT_WIDTH'(COUNT_FROM);
  localparam logic [COUNT_WIDTH-1:0] TO_C   = COUNT_WIDTH'(COUNT_TO);

  logic [WW-1:0]          w_count;
  logic [WW-1:0]          w_step;
  logic [WW-1:0]          w_sum;
  logic                   w_overshoot;
  logic [COUNT_WIDTH-1:0] w_bound;

  assign w_count = WW'(i_count);
  assign w_step  = WW'(i_step);
  assign w_sum   = i_dir ? (w_count + w_step) : (w_count - w_step);
  // Down overshoot tested as count < FROM + step so the wide value never goes negative.
  assign w_overshoot = i_dir ? (w_sum > TO_W) : (w_count < (FROM_W + w_step));
  assign w_bound     = i_dir ? TO_C : FROM_C;

  always_comb begin
    o_next      = i_count;
    o_hit_bound = 1'b0;
    o_clamped   = 1'b0;
    if (i_step != '0) begin
      if (w_overshoot) begin
        case (i_mode)
          CNT_SAT: begin
            o_next      = w_bound;
            o_clamped   = 1'b1;
            o_hit_bound = (i_count != w_bound);
          end
          CNT_ONESHOT: begin
            o_next      = w_bound;
            o_clamped   = 1'b1;
            o_hit_bound = 1'b1;
          end
          default: begin
            o_next      = i_dir ? FROM_C : TO_C;
            o_hit_bound = 1'b1;
          end
        endcase
      end else begin
        o_next      = w_sum[COUNT_WIDTH-1:0];
        o_hit_bound = (i_mode != CNT_WRAP) && (w_sum[COUNT_WIDTH-1:0] == w_bound);
      end
    end
  end
endmodule

// File: rtl/counter_multimode.sv
// counter_multimode: bounded up/down counter with variable step and
// runtime WRAP / SAT / ONESHOT mode, terminal-count pulse, sticky overflow.
//   clk  : rising-edge clock
//   rst  : asynchronous active-low reset
//   bus  : counter_multimode_if.slave (controls in, count/tc/ovf/busy out)
// Per-cycle priority: accepted start > load_en > en.
module counter_multimode
  import counter_pkg::*;
#(
  parameter int unsigned COUNT_WIDTH = 8,
  parameter int unsigned STEP_WIDTH  = 4,
  parameter int unsigned COUNT_FROM  = 0,
  parameter int unsigned COUNT_TO    = 255
) (
  input logic                clk,
  input logic                rst,
  counter_multimode_if.slave bus
);
  localparam logic [COUNT_WIDTH-1:0] FROM_C = COUNT_WIDTH'(COUNT_FROM);
  localparam logic [COUNT_WIDTH-1:0] TO_C   = COUNT_WIDTH'(COUNT_TO);

  logic [COUNT_WIDTH-1:0] r_count;
  logic                   r_tc;
  logic                   r_ovf;
  logic                   r_busy;
  cnt_state_e             r_state;

  logic [COUNT_WIDTH-1:0] w_count_nxt;
  logic                   w_tc_nxt;
  logic                   w_ovf_nxt;
  cnt_state_e             w_state_nxt;
  cnt_mode_e              w_mode;
  logic                   w_start_ok;
  logic [COUNT_WIDTH-1:0] w_load_clamped;
  logic [COUNT_WIDTH-1:0] w_step_next;
  logic                   w_hit_bound;
  logic                   w_clamped;

  assign w_mode     = decode_mode(bus.mode);
  assign w_start_ok = (w_mode == CNT_ONESHOT) && bus.start && (r_state != CNT_RUN);
  assign w_load_clamped = (bus.load_count < FROM_C) ? FROM_C :
                          (bus.load_count > TO_C)   ? TO_C   : bus.load_count;

  counter_next #(
    .COUNT_WIDTH (COUNT_WIDTH),
    .STEP_WIDTH  (STEP_WIDTH),
    .COUNT_FROM  (COUNT_FROM),
    .COUNT_TO    (COUNT_TO)
  ) u_next (
    .i_count     (r_count),
    .i_dir       (bus.dir),
    .i_step      (bus.step),
    .i_mode      (w_mode),
    .o_next      (w_step_next),
    .o_hit_bound (w_hit_bound),
    .o_clamped   (w_clamped)
  );

  always_comb begin
    w_count_nxt = r_count;
    w_tc_nxt    = 1'b0;
    w_ovf_nxt   = r_ovf;
    w_state_nxt = r_state;
    if (w_mode != CNT_ONESHOT) w_state_nxt = CNT_IDLE;

    if (w_start_ok) begin
      w_count_nxt = bus.dir ? FROM_C : TO_C;
      w_ovf_nxt   = 1'b0;
      w_state_nxt = CNT_RUN;
    end else if (bus.load_en) begin
      w_count_nxt = w_load_clamped;
      w_ovf_nxt   = 1'b0;
    end else if (bus.en) begin
      if (w_mode == CNT_ONESHOT) begin
        if (r_state == CNT_RUN) begin
          w_count_nxt = w_step_next;
          w_tc_nxt    = w_hit_bound;
          w_ovf_nxt   = r_ovf | w_clamped;
          if (w_hit_bound) w_state_nxt = CNT_DONE;
        end
      end else if (r_state != CNT_RUN) begin
        // r_state==RUN here means mode just left ONESHOT: hold for the return-to-IDLE cycle.
        w_count_nxt = w_step_next;
        w_tc_nxt    = w_hit_bound;
        w_ovf_nxt   = r_ovf | w_clamped;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_count <= FROM_C;
      r_tc    <= 1'b0;
      r_ovf   <= 1'b0;
      r_busy  <= 1'b0;
      r_state <= CNT_IDLE;
    end else begin
      r_count <= w_count_nxt;
      r_tc    <= w_tc_nxt;
      r_ovf   <= w_ovf_nxt;
      r_busy  <= (w_state_nxt == CNT_RUN);
      r_state <= w_state_nxt;
    end
  end

  assign bus.count = r_count;
  assign bus.tc    = r_tc;
  assign bus.ovf   = r_ovf;
  assign bus.busy  = r_busy;
endmodule

// File: tb/tb_counter_multimode.sv
// Directed bench for counter_multimode with COUNT_WIDTH=4, STEP_WIDTH=3,
// COUNT_FROM=2, COUNT_TO=11. Inputs change and outputs are checked 1 ns
// after each rising edge.
module tb_counter_multimode;
  logic clk;
  logic rst;
  int unsigned n_tests;
  int unsigned n_fail;

  counter_multimode_if #(.COUNT_WIDTH(4), .STEP_WIDTH(3)) bus ();

  counter_multimode #(
    .COUNT_WIDTH (4),
    .STEP_WIDTH  (3),
    .COUNT_FROM  (2),
    .COUNT_TO    (11)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag, input int c, input int t, input int o, input int b);
    chk({tag, ".count"}, 32'(bus.count), 32'(c));
    chk({tag, ".tc"},    32'(bus.tc),    32'(t));
    chk({tag, ".ovf"},   32'(bus.ovf),   32'(o));
    chk({tag, ".busy"},  32'(bus.busy),  32'(b));
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    rst = 1'b0;
    bus.en = 1'b0; bus.dir = 1'b1; bus.step = 3'd0; bus.mode = 2'd0;
    bus.start = 1'b0; bus.load_en = 1'b0; bus.load_count = 4'd0;

    // Reset state
    tick(); tick();
    chk_all("reset", 2, 0, 0, 0);
    rst = 1'b1;
    tick();
    chk_all("post_reset", 2, 0, 0, 0);

    // WRAP up, step 1: 3..11 then back to 2 with tc
    bus.en = 1'b1; bus.dir = 1'b1; bus.step = 3'd1; bus.mode = 2'd0;
    for (int e = 3; e <= 11; e++) begin
      tick();
      chk("wrap_up.count", 32'(bus.count), 32'(e));
      chk("wrap_up.tc", 32'(bus.tc), 32'd0);
    end
    tick();
    chk_all("wrap_up_wrap", 2, 1, 0, 0);
    // WRAP down from 2 wraps to 11
    bus.dir = 1'b0;
    tick();
    chk_all("wrap_down_wrap", 11, 1, 0, 0);

    // SAT down, step 3, after load 11
    bus.mode = 2'd1; bus.en = 1'b0; bus.load_en = 1'b1; bus.load_count = 4'd11;
    tick();
    chk_all("sat_load", 11, 0, 0, 0);
    bus.load_en = 1'b0; bus.en = 1'b1; bus.dir = 1'b0; bus.step = 3'd3;
    tick(); chk_all("sat_8", 8, 0, 0, 0);
    tick(); chk_all("sat_5", 5, 0, 0, 0);
    tick(); chk_all("sat_2_enter", 2, 1, 0, 0);
    tick(); chk_all("sat_2_clamp", 2, 0, 1, 0);
    tick(); chk_all("sat_2_hold", 2, 0, 1, 0);
    bus.en = 1'b0; bus.load_en = 1'b1; bus.load_count = 4'd7;
    tick(); chk_all("sat_load_clr", 7, 0, 0, 0);
    bus.load_en = 1'b0;

    // ONESHOT up, step 4
    bus.mode = 2'd2; bus.dir = 1'b1; bus.step = 3'd4; bus.en = 1'b1; bus.start = 1'b1;
    tick(); chk_all("os_start", 2, 0, 0, 1);
    bus.start = 1'b0;
    tick(); chk_all("os_6", 6, 0, 0, 1);
    tick(); chk_all("os_10", 10, 0, 0, 1);
    tick(); chk_all("os_clamp", 11, 1, 1, 0);
    tick(); chk_all("os_done_hold", 11, 0, 1, 0);
    bus.start = 1'b1;
    tick(); chk_all("os_restart", 2, 0, 0, 1);
    tick(); chk_all("os_start_ignored", 6, 0, 0, 1);
    bus.start = 1'b0; bus.en = 1'b0; bus.load_en = 1'b1; bus.load_count = 4'd7;
    tick(); chk_all("os_load_run", 7, 0, 0, 1);
    bus.load_en = 1'b0;

    // Asynchronous reset between edges
    #2 rst = 1'b0;
    #1 chk_all("async_reset", 2, 0, 0, 0);
    #2 rst = 1'b1;
    bus.mode = 2'd0;
    tick(); chk_all("after_async", 2, 0, 0, 0);

    // Load clamping and priority over en
    bus.load_en = 1'b1; bus.load_count = 4'd15;
    tick(); chk_all("load_15", 11, 0, 0, 0);
    bus.load_count = 4'd0;
    tick(); chk_all("load_0", 2, 0, 0, 0);
    bus.load_count = 4'd9; bus.en = 1'b1; bus.dir = 1'b1; bus.step = 3'd1;
    tick(); chk_all("load_vs_en_9", 9, 0, 0, 0);
    bus.load_count = 4'd11;
    tick(); chk_all("load_vs_en_11", 11, 0, 0, 0);
    bus.load_en = 1'b0;

    // step 0 holds; reserved mode decodes as WRAP
    bus.step = 3'd0;
    tick(); chk_all("step0_hold", 11, 0, 0, 0);
    bus.step = 3'd1; bus.mode = 2'd3;
    tick(); chk_all("mode3_wrap", 2, 1, 0, 0);

    // Mode change while RUN: FSM back to IDLE, count holds one cycle
    bus.mode = 2'd2; bus.start = 1'b1;
    tick(); chk_all("mc_start", 2, 0, 0, 1);
    bus.start = 1'b0; bus.mode = 2'd0;
    tick(); chk_all("mc_hold", 2, 0, 0, 0);
    tick(); chk_all("mc_wrap_step", 3, 0, 0, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
